// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - multi-channel PWM generator with shared period counter and double-buffered duty
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   en           run enable; while low the generator idles and reloads settings every cycle
//   mode         0 = edge-aligned, 1 = center-aligned (taken at period boundary)
//   period       period value P (taken at period boundary)
//   wr_en        duty write strobe
//   wr_ch        channel index for the duty write (out-of-range indices are ignored)
//   wr_duty      duty value written to the channel's shadow register
//   inv          per-channel output polarity invert
//   pwm_out      registered PWM outputs, one per channel
//   cycle_start  high in the first cycle (cnt == 0) of every PWM period
module pwm_multi_gen #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 mode,
    input  logic [CNT_W-1:0]                     period,
    input  logic                                 wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [CNT_W-1:0]                     wr_duty,
    input  logic [CH-1:0]                        inv,
    output logic [CH-1:0]                        pwm_out,
    output logic                                 cycle_start
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_act;
    logic             dir;       // 0 = counting up, 1 = counting down
    logic             m_act;
    logic             start_q;
    logic             boundary;
    logic [CH-1:0]    hit;
    logic [CNT_W-1:0] shadow [CH];
    logic [CNT_W-1:0] active [CH];

    // Last cycle of the current period. While disabled every cycle counts as
    // a boundary so the settings stay fresh for the moment en rises.
    always_comb begin
        boundary = 1'b0;
        if (!en || p_act == '0) begin
            boundary = 1'b1;
        end else if (!m_act) begin
            boundary = (cnt == p_act);
        end else begin
            boundary = (dir && cnt == ONE) || (p_act == ONE && cnt == p_act);
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < CH; i++) begin
            hit[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            dir     <= 1'b0;
            p_act   <= '0;
            m_act   <= 1'b0;
            pwm_out <= '0;
            start_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= en ? ((cnt < active[i]) ^ inv[i]) : inv[i];
                if (hit[i]) begin
                    shadow[i] <= wr_duty;
                end
                // A write landing on the boundary bypasses the shadow so it
                // is not lost for a whole period.
                if (boundary) begin
                    active[i] <= hit[i] ? wr_duty : shadow[i];
                end
            end

            start_q <= boundary;

            if (boundary) begin
                cnt   <= '0;
                dir   <= 1'b0;
                p_act <= period;
                m_act <= mode;
            end else if (!m_act) begin
                cnt <= cnt + ONE;
            end else if (!dir) begin
                if (cnt == p_act) begin
                    dir <= 1'b1;
                    cnt <= cnt - ONE;
                end else begin
                    cnt <= cnt + ONE;
                end
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

    // The start flag is gated by en so it stays quiet while idle yet still
    // marks the first cycle after en rises.
    assign cycle_start = start_q & en;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - self-checking bench for pwm_multi_gen
module tb_pwm_multi_gen;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] period = '0;
    logic [W-1:0] wr_duty = '0;
    logic [1:0]   wr_ch = '0;
    logic [3:0]   inv = '0;
    logic [2:0]   inv3 = '0;
    logic [3:0]   pwm_out;
    logic [2:0]   pwm3;
    logic         cycle_start;
    logic         cs3;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(.CH(4), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .inv(inv),
        .pwm_out(pwm_out), .cycle_start(cycle_start)
    );

    pwm_multi_gen #(.CH(3), .CNT_W(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .inv(inv3),
        .pwm_out(pwm3), .cycle_start(cs3)
    );

    // Reference model: tracks the position inside the current period rather
    // than a counter/direction pair; the counter value is derived from it.
    logic [3:0]   m_pwm;
    logic         m_start;
    logic [W-1:0] m_sh [4];
    logic [W-1:0] m_act [4];
    int           m_p;
    int           m_pos;
    logic         m_m;

    always @(posedge clk) begin
        int len;
        int c;
        logic last;
        if (!rst_n) begin
            m_p     <= 0;
            m_m     <= 1'b0;
            m_pos   <= 0;
            m_pwm   <= '0;
            m_start <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i]  <= '0;
                m_act[i] <= '0;
            end
        end else begin
            len  = (m_p == 0) ? 1 : (m_m ? 2 * m_p : m_p + 1);
            c    = (m_pos > m_p) ? 2 * m_p - m_pos : m_pos;
            last = !en || (m_pos == len - 1);
            for (int i = 0; i < 4; i++) begin
                m_pwm[i] <= en ? ((c < int'(m_act[i])) ^ inv[i]) : inv[i];
            end
            m_start <= last;
            if (last) begin
                m_pos <= 0;
                m_p   <= int'(period);
                m_m   <= mode;
                for (int i = 0; i < 4; i++) begin
                    m_act[i] <= (wr_en && int'(wr_ch) == i) ? wr_duty : m_sh[i];
                end
            end else begin
                m_pos <= m_pos + 1;
            end
            if (wr_en) m_sh[wr_ch] <= wr_duty;
        end
    end

    task automatic do_write(input logic [1:0] c, input logic [W-1:0] d);
        wr_en = 1'b1; wr_ch = c; wr_duty = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Waits for a period start, then observes len cycles of output (which
    // reflect the counter of that period, one cycle late). Optional write and
    // period/mode change at given offsets inside the period.
    task automatic measure(input int len, input int wr_at, input logic [1:0] wch,
                           input logic [W-1:0] wd, input int per_at, input logic [W-1:0] pval,
                           input logic mval, output int hi[4], output int hi3[3],
                           output int mm, output int cc, output bit f, output bit ce);
        int n;
        n = 0; mm = 0; cc = 0; ce = 1'b0;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int i = 0; i < 3; i++) hi3[i] = 0;
        while (cycle_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        f = (cycle_start === 1'b1);
        for (int j = 0; j < len; j++) begin
            if (j == wr_at) begin
                wr_en = 1'b1; wr_ch = wch; wr_duty = wd;
            end
            if (j == per_at) begin
                period = pval; mode = mval;
            end
            @(negedge clk);
            wr_en = 1'b0;
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
            for (int i = 0; i < 3; i++) hi3[i] += int'(pwm3[i]);
            if (pwm_out !== m_pwm || cycle_start !== (m_start & en)) mm++;
            if (cycle_start === 1'b1) cc++;
            if (j == len - 1) ce = cycle_start;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; inv = 4'b1111;
        repeat (2) @(negedge clk);
        total++;
        if (pwm_out !== 4'b0000 || cycle_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got pwm=%b cs=%b want pwm=0000 cs=0", pwm_out, cycle_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (pwm_out !== 4'b1111 || cycle_start !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got pwm=%b cs=%b want pwm=1111 cs=1", pwm_out, cycle_start);
        end
        inv = 4'b0000;
    endtask

    task automatic test_edge();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        int e[4];
        e = '{3, 0, 10, 9};
        mode = 1'b0; period = 8'd9;
        do_write(2'd0, 8'd3);
        do_write(2'd1, 8'd0);
        do_write(2'd2, 8'd10);
        do_write(2'd3, 8'd9);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (hi[i] !== e[i]) begin
                bad++;
                $display("FAIL edge_high_ch%0d got=%0d want=%0d", i, hi[i], e[i]);
            end
        end
        total++;
        if (f !== 1'b1 || cc !== 1 || ce !== 1'b1 || mm !== 0) begin
            bad++;
            $display("FAIL edge_period got found=%0d starts=%0d end=%0d model_diff=%0d want 1 1 1 0", f, cc, ce, mm);
        end
    endtask

    task automatic test_center();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        int e[4];
        e = '{3, 0, 8, 8};
        measure(10, 2, 2'd0, 8'd2, 3, 8'd4, 1'b1, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 3 || cc !== 1 || ce !== 1'b1 || mm !== 0) begin
            bad++;
            $display("FAIL center_pending got hi0=%0d starts=%0d end=%0d model_diff=%0d want 3 1 1 0", hi[0], cc, ce, mm);
        end
        measure(8, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (hi[i] !== e[i]) begin
                bad++;
                $display("FAIL center_high_ch%0d got=%0d want=%0d", i, hi[i], e[i]);
            end
        end
        total++;
        if (cc !== 1 || ce !== 1'b1 || mm !== 0) begin
            bad++;
            $display("FAIL center_period got starts=%0d end=%0d model_diff=%0d want 1 1 0", cc, ce, mm);
        end
    endtask

    task automatic test_mid_write();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        measure(8, -1, 2'd0, 8'd0, 0, 8'd9, 1'b0, hi, hi3, mm, cc, f, ce);
        measure(10, 3, 2'd0, 8'd7, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 2 || mm !== 0) begin
            bad++;
            $display("FAIL midwrite_old got hi0=%0d model_diff=%0d want 2 0", hi[0], mm);
        end
        measure(10, 9, 2'd0, 8'd5, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 7 || mm !== 0) begin
            bad++;
            $display("FAIL midwrite_new got hi0=%0d model_diff=%0d want 7 0", hi[0], mm);
        end
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 5 || mm !== 0) begin
            bad++;
            $display("FAIL boundary_write got hi0=%0d model_diff=%0d want 5 0", hi[0], mm);
        end
    endtask

    task automatic test_period_change();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        measure(10, -1, 2'd0, 8'd0, 4, 8'd4, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (cc !== 1 || ce !== 1'b1 || hi[0] !== 5 || mm !== 0) begin
            bad++;
            $display("FAIL period_keep got starts=%0d end=%0d hi0=%0d model_diff=%0d want 1 1 5 0", cc, ce, hi[0], mm);
        end
        measure(5, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (cc !== 1 || ce !== 1'b1 || hi[0] !== 5 || hi[1] !== 0 || hi[2] !== 5 || mm !== 0) begin
            bad++;
            $display("FAIL period_new got starts=%0d end=%0d hi0=%0d hi1=%0d hi2=%0d model_diff=%0d want 1 1 5 0 5 0",
                     cc, ce, hi[0], hi[1], hi[2], mm);
        end
        measure(5, -1, 2'd0, 8'd0, 0, 8'd9, 1'b0, hi, hi3, mm, cc, f, ce);
    endtask

    task automatic test_inv_en_reset();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        do_write(2'd0, 8'd3);
        inv = 4'b0001;
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 7 || mm !== 0) begin
            bad++;
            $display("FAIL inv_high got hi0=%0d model_diff=%0d want 7 0", hi[0], mm);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (pwm_out !== 4'b0001 || cycle_start !== 1'b0) begin
            bad++;
            $display("FAIL en_off got pwm=%b cs=%b want pwm=0001 cs=0", pwm_out, cycle_start);
        end
        en = 1'b1;
        #1;
        total++;
        if (cycle_start !== 1'b1) begin
            bad++;
            $display("FAIL en_rise_start got cs=%b want 1", cycle_start);
        end
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi[0] !== 7 || cc !== 1 || mm !== 0) begin
            bad++;
            $display("FAIL en_first_period got hi0=%0d starts=%0d model_diff=%0d want 7 1 0", hi[0], cc, mm);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (pwm_out !== 4'b0000 || cycle_start !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got pwm=%b cs=%b want pwm=0000 cs=0", pwm_out, cycle_start);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_period();
        inv = 4'b0000; period = 8'd0;
        do_write(2'd0, 8'd1);
        do_write(2'd1, 8'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (cycle_start !== 1'b1 || pwm_out !== 4'b0001 || m_pwm !== pwm_out) begin
                bad++;
                $display("FAIL zero_period cyc%0d got cs=%b pwm=%b want cs=1 pwm=0001", k, cycle_start, pwm_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_out_of_range();
        int hi[4]; int hi3[3]; int mm, cc; bit f, ce;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; mode = 1'b0; period = 8'd9; inv = 4'b0000; inv3 = 3'b000;
        do_write(2'd3, 8'd5);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi3[0] !== 0 || hi3[1] !== 0 || hi3[2] !== 0 || hi[3] !== 5) begin
            bad++;
            $display("FAIL wr_ch_range got ch3x=%0d/%0d/%0d ch4x_3=%0d want 0/0/0 5", hi3[0], hi3[1], hi3[2], hi[3]);
        end
        measure(10, 0, 2'd2, 8'd5, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        measure(10, -1, 2'd0, 8'd0, -1, 8'd0, 1'b0, hi, hi3, mm, cc, f, ce);
        total++;
        if (hi3[2] !== 5 || hi3[0] !== 0) begin
            bad++;
            $display("FAIL wr_ch_valid got ch2=%0d ch0=%0d want 5 0", hi3[2], hi3[0]);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            total++;
            if (pwm_out !== m_pwm || cycle_start !== (m_start & en)) begin
                bad++;
                $display("FAIL random cyc%0d got pwm=%b cs=%b want pwm=%b cs=%b",
                         k, pwm_out, cycle_start, m_pwm, m_start & en);
            end
            wr_en   = ($urandom % 3 == 0);
            wr_ch   = 2'($urandom % 4);
            wr_duty = 8'($urandom_range(0, 12));
            if ($urandom % 15 == 0) period = 8'($urandom_range(0, 10));
            if ($urandom % 20 == 0) mode = 1'($urandom % 2);
            if ($urandom % 50 == 0) inv = 4'($urandom % 16);
            en = ($urandom % 40 != 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_edge();
        test_center();
        test_mid_write();
        test_period_change();
        test_inv_en_reset();
        test_zero_period();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Parametrised multi-channel PWM generator; next generation of the single-channel 4-bit duty PWM block.
- Provides a shared period counter, edge- or center-aligned mode, per-channel duty with shadow/active double buffering, and per-channel output polarity.
- Sits between the pin-level I/O wrapper and the duty-write interface.
- Duty, period and mode changes take effect only at period boundaries, so no glitched PWM cycles are produced.

Parameters:
- CH, 4, number of PWM channels (1..8)
- CNT_W, 8, width of counter, period and duty values (2..16)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- en  in  1  run enable
- mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at boundary
- period  in  CNT_W  period value P; sampled at boundary
- wr_en  in  1  duty write strobe
- wr_ch  in  clog2(CH) (min 1)  channel index for write
- wr_duty  in  CNT_W  duty value D
- inv  in  CH  per-channel output polarity invert
- pwm_out  out  CH  registered PWM outputs
- cycle_start  out  1  one-cycle pulse, first cycle of each PWM period

Behaviour:
- Reset (rst_n=0 at posedge): all of the following go to 0: cnt, dir (0 = up), shadow[], active[], p_act, m_act, pwm_out, cycle_start. pwm_out is 0 during reset regardless of inv. Reset mid-period aborts the period immediately.
- Write: on posedge with wr_en=1, shadow[wr_ch] <= wr_duty.
  - wr_ch >= CH: write ignored.
  - Writes are accepted regardless of en.
- Edge mode (m_act=0):
  - cnt sequence 0,1,...,p_act,0,...; period length p_act+1 cycles.
  - Boundary cycle: cnt==p_act.
- Center mode (m_act=1):
  - cnt sequence 0,1,...,p_act,p_act-1,...,1, then 0; period length 2*p_act cycles.
  - dir flips to down when cnt==p_act, and back to up when cnt returns to 0.
  - Boundary cycle: dir=down and cnt==1, or cnt==p_act when p_act==1.
- p_act==0 (either mode): cnt holds at 0; every cycle is a boundary.
- At a boundary posedge:
  - cnt <= 0; dir <= up.
  - p_act <= period; m_act <= mode.
  - active[i] <= shadow[i] for all i.
- Write/boundary collision: if wr_en hits channel i in the boundary cycle, active[i] loads wr_duty (bypass). The new value is visible in the first cycle of the next period.
- Output: pwm_out[i] <= (cnt < active[i]) XOR inv[i], registered, so pwm_out lags cnt by 1 cycle.
  - Edge mode: D=0 gives constant low; D>p_act gives constant high; otherwise D high cycles per period.
  - Center mode: D=0 gives low; 1<=D<=p_act gives 2D-1 high cycles, centered on cnt=0; D>p_act gives constant high.
- cycle_start <= 1 on the posedge following a boundary, i.e. high in the cycle where cnt==0 begins a new period. Otherwise 0.
- en=0:
  - cnt and dir hold at 0/up; pwm_out <= inv; cycle_start=0.
  - Every cycle is treated as a boundary: active, p_act and m_act keep reloading.
  - On en 0->1 the first period starts with cnt=0 and fresh values, and cycle_start pulses in that first cycle.
- Arithmetic: all comparisons are unsigned CNT_W. cnt never exceeds p_act, so there is no wrap overflow. Changing period mid-period has no effect until the boundary.

Test Plan:
- Reset, then en=1, mode=0, P=9, write ch0 D=3, ch1 D=0, ch2 D=10, ch3 D=9 -> per 10-cycle period: ch0 high 3, ch1 always 0, ch2 always 1, ch3 high 9; cycle_start every 10 cycles.
- Mode=1, P=4, ch0 D=2 -> period 8 cycles; cnt 0,1,2,3,4,3,2,1; ch0 high for cnt 0,1 and 1 (3 cycles); mode change applied only after boundary.
- Mid-period write of ch0 D=7 with P=9 -> current period keeps old duty; next period shows 7 high cycles. Write landing exactly on the boundary cycle -> new duty in the immediately following period.
- Mid-period change of P from 9 to 4 -> current period completes at cnt==9; next period is 5 cycles long.
- inv=4'b0001 with ch0 D=3, P=9 -> ch0 low 3, high 7. en=0 -> pwm_out=0001, cycle_start=0. Assert rst_n=0 mid-period -> next cycle pwm_out=0, cnt=0.
- P=0 -> cnt stuck at 0, cycle_start high every cycle, D>=1 gives constant high. Write with wr_ch out of range (CH=3, wr_ch=3) -> no channel changes.
